// File: rtl/lc3_pkg.sv
// Shared LC-3 execute-stage definitions: opcodes, E_Control field layout,
// ALU/offset encodings and the sign-extension / opcode-class helpers.
package lc3_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    // E_Control = {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
    localparam int ECTL_ALU_HI  = 5;
    localparam int ECTL_ALU_LO  = 4;
    localparam int ECTL_PCS1_HI = 3;
    localparam int ECTL_PCS1_LO = 2;
    localparam int ECTL_PCSEL2  = 1;
    localparam int ECTL_OP2SEL  = 0;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_AND  = 2'b01,
        ALU_NOT  = 2'b10,
        ALU_RSVD = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        PCS_OFF11 = 2'b00,
        PCS_OFF9  = 2'b01,
        PCS_OFF6  = 2'b10,
        PCS_ZERO  = 2'b11
    } pcsel1_t;

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

    function automatic logic [15:0] sext9(input logic [8:0] v);
        return {{7{v[8]}}, v};
    endfunction

    function automatic logic [15:0] sext11(input logic [10:0] v);
        return {{5{v[10]}}, v};
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

    function automatic logic writes_dr(input logic [3:0] op);
        return is_alu_op(op) || (op == OP_LD) || (op == OP_LDR) ||
               (op == OP_LDI) || (op == OP_LEA);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    // JMP is an unconditional taken branch, so it presents an all-ones mask.
    function automatic logic [2:0] nzp_mask(input logic [3:0] op, input logic [2:0] cond);
        logic [2:0] m;
        m = 3'b000;
        if (op == OP_BR)
            m = cond;
        else if (op == OP_JMP)
            m = 3'b111;
        return m;
    endfunction

endpackage

// File: rtl/execute_if.sv
// Decode-to-execute input bundle and execute-to-memaccess/writeback output bundle.
interface execute_if;

    // Flow control: the stage has no backpressure. When enable_execute is high
    // at a rising edge the inputs are consumed and results appear one cycle
    // later; when low the registered results hold (NZP clears).
    logic        enable_execute;
    logic [15:0] IR;
    logic [15:0] npc_in;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control_in;
    logic        Mem_Control_in;
    logic [15:0] VSR1;
    logic [15:0] VSR2;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic        bypass_mem_1;
    logic        bypass_mem_2;
    logic [15:0] Mem_Bypass_Val;

    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [15:0] aluout;
    logic [15:0] pcout;
    logic [2:0]  dr;
    logic [15:0] M_Data;
    logic [15:0] IR_Exec;
    logic [2:0]  NZP;
    logic [1:0]  W_Control_out;
    logic        Mem_Control_out;

    modport master (
        output enable_execute, IR, npc_in, E_Control, W_Control_in, Mem_Control_in,
               VSR1, VSR2, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
               Mem_Bypass_Val,
        input  sr1, sr2, aluout, pcout, dr, M_Data, IR_Exec, NZP,
               W_Control_out, Mem_Control_out
    );

    modport slave (
        input  enable_execute, IR, npc_in, E_Control, W_Control_in, Mem_Control_in,
               VSR1, VSR2, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
               Mem_Bypass_Val,
        output sr1, sr2, aluout, pcout, dr, M_Data, IR_Exec, NZP,
               W_Control_out, Mem_Control_out
    );

endinterface

// File: rtl/lc3_alu.sv
// Combinational LC-3 ALU: ADD, AND, NOT(op1); the reserved encoding yields zero.
module lc3_alu
    import lc3_pkg::*;
(
    input  logic [15:0] i_op1,
    input  logic [15:0] i_op2,
    input  alu_op_t     i_alu_control,
    output logic [15:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_alu_control)
            ALU_ADD:  o_result = i_op1 + i_op2;
            ALU_AND:  o_result = i_op1 & i_op2;
            ALU_NOT:  o_result = ~i_op1;
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/execute.sv
// LC-3 execute stage: operand bypass, ALU, effective-address adder and the
// registered results handed to memaccess/writeback (1-cycle latency).
module execute
    import lc3_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    execute_if.slave   bus
);

    logic [3:0]  w_opcode;
    logic [15:0] w_op1;
    logic [15:0] w_op2;
    logic [15:0] w_alu_b;
    logic [15:0] w_alu_result;
    logic [15:0] w_offset;
    logic [15:0] w_base;
    logic [15:0] w_addr;
    logic [2:0]  w_dr;
    logic [2:0]  w_nzp;
    alu_op_t     w_alu_ctl;
    pcsel1_t     w_pcsel1;

    logic [15:0] r_aluout;
    logic [15:0] r_pcout;
    logic [2:0]  r_dr;
    logic [15:0] r_m_data;
    logic [15:0] r_ir_exec;
    logic [2:0]  r_nzp;
    logic [1:0]  r_w_control;
    logic        r_mem_control;

    assign w_opcode  = bus.IR[15:12];
    assign w_alu_ctl = alu_op_t'(bus.E_Control[ECTL_ALU_HI:ECTL_ALU_LO]);
    assign w_pcsel1  = pcsel1_t'(bus.E_Control[ECTL_PCS1_HI:ECTL_PCS1_LO]);

    assign bus.sr1 = bus.IR[8:6];
    assign bus.sr2 = is_store(w_opcode) ? bus.IR[11:9] : bus.IR[2:0];

    // The ALU bypass carries the newer result, so it outranks the memory bypass.
    always_comb begin
        w_op1 = bus.VSR1;
        if (bus.bypass_alu_1)
            w_op1 = r_aluout;
        else if (bus.bypass_mem_1)
            w_op1 = bus.Mem_Bypass_Val;
    end

    always_comb begin
        w_op2 = bus.VSR2;
        if (bus.bypass_alu_2)
            w_op2 = r_aluout;
        else if (bus.bypass_mem_2)
            w_op2 = bus.Mem_Bypass_Val;
    end

    assign w_alu_b = bus.E_Control[ECTL_OP2SEL] ? w_op2 : sext5(bus.IR[4:0]);

    lc3_alu u_alu (
        .i_op1         (w_op1),
        .i_op2         (w_alu_b),
        .i_alu_control (w_alu_ctl),
        .o_result      (w_alu_result)
    );

    always_comb begin
        w_offset = '0;
        case (w_pcsel1)
            PCS_OFF11: w_offset = sext11(bus.IR[10:0]);
            PCS_OFF9:  w_offset = sext9(bus.IR[8:0]);
            PCS_OFF6:  w_offset = sext6(bus.IR[5:0]);
            default:   w_offset = '0;
        endcase
    end

    assign w_base = bus.E_Control[ECTL_PCSEL2] ? bus.npc_in : w_op1;
    // 16-bit modulo add: the carry out is intentionally dropped.
    assign w_addr = w_base + w_offset;
    assign w_dr   = writes_dr(w_opcode) ? bus.IR[11:9] : 3'b000;
    assign w_nzp  = nzp_mask(w_opcode, bus.IR[11:9]);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_aluout      <= '0;
            r_pcout       <= '0;
            r_dr          <= '0;
            r_m_data      <= '0;
            r_ir_exec     <= '0;
            r_nzp         <= '0;
            r_w_control   <= '0;
            r_mem_control <= 1'b0;
        end else if (bus.enable_execute) begin
            r_aluout      <= is_alu_op(w_opcode) ? w_alu_result : w_addr;
            r_pcout       <= w_addr;
            r_dr          <= w_dr;
            r_m_data      <= w_op2;
            r_ir_exec     <= bus.IR;
            r_nzp         <= w_nzp;
            r_w_control   <= bus.W_Control_in;
            r_mem_control <= bus.Mem_Control_in;
        end else begin
            // A stalled stage must not let the controller see the same branch twice.
            r_nzp         <= 3'b000;
        end
    end

    assign bus.aluout          = r_aluout;
    assign bus.pcout           = r_pcout;
    assign bus.dr              = r_dr;
    assign bus.M_Data          = r_m_data;
    assign bus.IR_Exec         = r_ir_exec;
    assign bus.NZP             = r_nzp;
    assign bus.W_Control_out   = r_w_control;
    assign bus.Mem_Control_out = r_mem_control;

endmodule

// File: tb/tb_execute.sv
// Bench for the LC-3 execute stage: directed vector table, stall/reset
// sequences, and randomized traffic checked against an arithmetic model.
module tb_execute;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    execute_if bus();

    execute dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: what each registered output should hold.
    int m_alu, m_pc, m_dr, m_nzp, m_md, m_irx, m_w, m_m;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] npc;
        logic [5:0]  ectl;
        logic [15:0] vsr1;
        logic [15:0] vsr2;
        logic [3:0]  byp;   // {alu_1, mem_1, alu_2, mem_2}
        logic [15:0] mbv;
        logic [1:0]  w;
        logic        m;
        logic [15:0] e_alu;
        logic [15:0] e_pc;
        logic [2:0]  e_dr;
        logic [2:0]  e_nzp;
        logic [15:0] e_md;
    } vec_t;

    vec_t vecs[14];

    function automatic int sx(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        int op, ir, op1, op2, imm, b, r, off, base, addr;
        if (reset) begin
            m_alu = 0; m_pc = 0; m_dr = 0; m_nzp = 0;
            m_md = 0; m_irx = 0; m_w = 0; m_m = 0;
        end else if (!bus.enable_execute) begin
            m_nzp = 0;
        end else begin
            ir  = int'(bus.IR);
            op  = ir / 4096;
            op1 = bus.bypass_alu_1 ? m_alu : bus.bypass_mem_1 ? int'(bus.Mem_Bypass_Val) : int'(bus.VSR1);
            op2 = bus.bypass_alu_2 ? m_alu : bus.bypass_mem_2 ? int'(bus.Mem_Bypass_Val) : int'(bus.VSR2);
            imm = sx(ir % 32, 5);
            b   = bus.E_Control[0] ? op2 : imm;
            case (int'(bus.E_Control[5:4]))
                0:       r = (op1 + b) & 65535;
                1:       r = op1 & (b & 65535);
                2:       r = 65535 - op1;
                default: r = 0;
            endcase
            case (int'(bus.E_Control[3:2]))
                0:       off = sx(ir % 2048, 11);
                1:       off = sx(ir % 512, 9);
                2:       off = sx(ir % 64, 6);
                default: off = 0;
            endcase
            base = bus.E_Control[1] ? int'(bus.npc_in) : op1;
            addr = (base + off) & 65535;
            m_pc  = addr;
            m_alu = (op == 1 || op == 5 || op == 9) ? r : addr;
            m_dr  = (op == 1 || op == 5 || op == 9 || op == 2 || op == 6 || op == 10 || op == 14)
                    ? (ir / 512) % 8 : 0;
            m_nzp = (op == 0) ? (ir / 512) % 8 : (op == 12) ? 7 : 0;
            m_md  = op2;
            m_irx = ir;
            m_w   = int'(bus.W_Control_in);
            m_m   = int'(bus.Mem_Control_in);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_sr(input string tag);
        int op, ir;
        ir = int'(bus.IR);
        op = ir / 4096;
        chk({tag, ".sr1"}, int'(bus.sr1), (ir / 64) % 8);
        chk({tag, ".sr2"}, int'(bus.sr2), (op == 3 || op == 7 || op == 11) ? (ir / 512) % 8 : ir % 8);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".aluout"},  int'(bus.aluout),          m_alu);
        chk({tag, ".pcout"},   int'(bus.pcout),           m_pc);
        chk({tag, ".dr"},      int'(bus.dr),              m_dr);
        chk({tag, ".NZP"},     int'(bus.NZP),             m_nzp);
        chk({tag, ".M_Data"},  int'(bus.M_Data),          m_md);
        chk({tag, ".IR_Exec"}, int'(bus.IR_Exec),         m_irx);
        chk({tag, ".W_out"},   int'(bus.W_Control_out),   m_w);
        chk({tag, ".Mem_out"}, int'(bus.Mem_Control_out), m_m);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".aluout"},  int'(bus.aluout),          0);
        chk({tag, ".pcout"},   int'(bus.pcout),           0);
        chk({tag, ".dr"},      int'(bus.dr),              0);
        chk({tag, ".NZP"},     int'(bus.NZP),             0);
        chk({tag, ".M_Data"},  int'(bus.M_Data),          0);
        chk({tag, ".IR_Exec"}, int'(bus.IR_Exec),         0);
        chk({tag, ".W_out"},   int'(bus.W_Control_out),   0);
        chk({tag, ".Mem_out"}, int'(bus.Mem_Control_out), 0);
    endtask

    task automatic drive_vec(input vec_t v);
        bus.IR             = v.ir;
        bus.npc_in         = v.npc;
        bus.E_Control      = v.ectl;
        bus.VSR1           = v.vsr1;
        bus.VSR2           = v.vsr2;
        bus.bypass_alu_1   = v.byp[3];
        bus.bypass_mem_1   = v.byp[2];
        bus.bypass_alu_2   = v.byp[1];
        bus.bypass_mem_2   = v.byp[0];
        bus.Mem_Bypass_Val = v.mbv;
        bus.W_Control_in   = v.w;
        bus.Mem_Control_in = v.m;
    endtask

    task automatic drive_rand();
        bus.IR             = 16'($urandom);
        bus.npc_in         = 16'($urandom);
        bus.E_Control      = 6'($urandom);
        bus.VSR1           = 16'($urandom);
        bus.VSR2           = 16'($urandom);
        bus.bypass_alu_1   = 1'($urandom_range(0, 1));
        bus.bypass_mem_1   = 1'($urandom_range(0, 1));
        bus.bypass_alu_2   = 1'($urandom_range(0, 1));
        bus.bypass_mem_2   = 1'($urandom_range(0, 1));
        bus.Mem_Bypass_Val = 16'($urandom);
        bus.W_Control_in   = 2'($urandom);
        bus.Mem_Control_in = 1'($urandom);
    endtask

    initial begin
        vecs[0]  = '{16'h1265, 16'h0000, 6'b000000, 16'h0003, 16'h1111, 4'b0000, 16'h0000, 2'b01, 1'b0,
                     16'h0008, 16'h0268, 3'd1, 3'b000, 16'h1111};
        vecs[1]  = '{16'h1265, 16'h0000, 6'b000000, 16'h00FA, 16'h0000, 4'b0000, 16'h0000, 2'b00, 1'b0,
                     16'h00FF, 16'h035F, 3'd1, 3'b000, 16'h0000};
        vecs[2]  = '{16'h5042, 16'h0000, 6'b010001, 16'h1234, 16'h5678, 4'b1001, 16'h0F0F, 2'b11, 1'b1,
                     16'h000F, 16'h0141, 3'd0, 3'b000, 16'h0F0F};
        vecs[3]  = '{16'h5042, 16'h0000, 6'b010001, 16'h00F3, 16'h5678, 4'b0011, 16'h0F0F, 2'b00, 1'b0,
                     16'h0003, 16'h0135, 3'd0, 3'b000, 16'h000F};
        vecs[4]  = '{16'h21FF, 16'h0000, 6'b000110, 16'h1234, 16'h2222, 4'b0000, 16'h0000, 2'b10, 1'b1,
                     16'hFFFF, 16'hFFFF, 3'd0, 3'b000, 16'h2222};
        vecs[5]  = '{16'h0A05, 16'h3001, 6'b000110, 16'h0000, 16'h3333, 4'b0000, 16'h0000, 2'b00, 1'b0,
                     16'h3006, 16'h3006, 3'd0, 3'b101, 16'h3333};
        vecs[6]  = '{16'h7681, 16'h0000, 6'b001000, 16'h4000, 16'hBEEF, 4'b0000, 16'h0000, 2'b00, 1'b1,
                     16'h4001, 16'h4001, 3'd0, 3'b000, 16'hBEEF};
        vecs[7]  = '{16'hC1C0, 16'h0000, 6'b001100, 16'h5000, 16'h0000, 4'b0000, 16'h0000, 2'b00, 1'b0,
                     16'h5000, 16'h5000, 3'd0, 3'b111, 16'h0000};
        vecs[8]  = '{16'h927F, 16'h0000, 6'b100000, 16'h00FF, 16'h0000, 4'b0000, 16'h0000, 2'b01, 1'b0,
                     16'hFF00, 16'h037E, 3'd1, 3'b000, 16'h0000};
        vecs[9]  = '{16'h1265, 16'h0000, 6'b110000, 16'h0003, 16'h0000, 4'b0000, 16'h0000, 2'b00, 1'b0,
                     16'h0000, 16'h0268, 3'd1, 3'b000, 16'h0000};
        vecs[10] = '{16'hE3FE, 16'h3000, 6'b000110, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 2'b00, 1'b0,
                     16'h2FFE, 16'h2FFE, 3'd1, 3'b000, 16'h0000};
        vecs[11] = '{16'hF025, 16'h0000, 6'b001100, 16'h1234, 16'h0000, 4'b0000, 16'h0000, 2'b00, 1'b0,
                     16'h1234, 16'h1234, 3'd0, 3'b000, 16'h0000};
        vecs[12] = '{16'h1265, 16'h0000, 6'b000000, 16'h9999, 16'h0000, 4'b0100, 16'h0010, 2'b00, 1'b0,
                     16'h0015, 16'h0275, 3'd1, 3'b000, 16'h0000};
        vecs[13] = '{16'h1265, 16'h0000, 6'b000000, 16'h9999, 16'h0000, 4'b1100, 16'h0010, 2'b00, 1'b0,
                     16'h001A, 16'h027A, 3'd1, 3'b000, 16'h0000};

        // Reset held for two edges while enabled with busy inputs.
        reset = 1'b1;
        bus.enable_execute = 1'b1;
        drive_vec(vecs[6]);
        tick();
        chk_zero("reset1");
        drive_vec(vecs[2]);
        tick();
        chk_zero("reset2");
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive_vec(vecs[i]);
            bus.enable_execute = 1'b1;
            #1;
            chk_sr($sformatf("vec%0d", i));
            tick();
            chk($sformatf("vec%0d.aluout", i),  int'(bus.aluout),          int'(vecs[i].e_alu));
            chk($sformatf("vec%0d.pcout", i),   int'(bus.pcout),           int'(vecs[i].e_pc));
            chk($sformatf("vec%0d.dr", i),      int'(bus.dr),              int'(vecs[i].e_dr));
            chk($sformatf("vec%0d.NZP", i),     int'(bus.NZP),             int'(vecs[i].e_nzp));
            chk($sformatf("vec%0d.M_Data", i),  int'(bus.M_Data),          int'(vecs[i].e_md));
            chk($sformatf("vec%0d.IR_Exec", i), int'(bus.IR_Exec),         int'(vecs[i].ir));
            chk($sformatf("vec%0d.W_out", i),   int'(bus.W_Control_out),   int'(vecs[i].w));
            chk($sformatf("vec%0d.Mem_out", i), int'(bus.Mem_Control_out), int'(vecs[i].m));
            if (i == 5) begin
                // Stall right after the branch: mask clears, everything else holds.
                bus.enable_execute = 1'b0;
                drive_rand();
                tick();
                chk("stall.NZP",     int'(bus.NZP),     0);
                chk("stall.pcout",   int'(bus.pcout),   16'h3006);
                chk("stall.aluout",  int'(bus.aluout),  16'h3006);
                chk("stall.M_Data",  int'(bus.M_Data),  16'h3333);
                chk("stall.IR_Exec", int'(bus.IR_Exec), 16'h0A05);
                tick();
                chk("stall2.pcout",  int'(bus.pcout),   16'h3006);
            end
        end

        // Randomized traffic with stalls and occasional resets.
        for (int n = 0; n < 400; n++) begin
            drive_rand();
            bus.enable_execute = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 29) == 0);
            #1;
            chk_sr("rand");
            tick();
            chk_model("rand");
        end

        // Reset wins over an enabled, busy stage.
        reset = 1'b0;
        bus.enable_execute = 1'b1;
        drive_vec(vecs[5]);
        tick();
        chk_model("pre_reset");
        reset = 1'b1;
        drive_vec(vecs[8]);
        tick();
        chk_zero("midreset");
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
